// File: rtl/bbc_bus_target_pkg.sv
// Shared constants for the BBC bus target: register offsets, register bit
// positions, FSM state encoding and a small count-saturation helper.
package bbc_bus_target_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int STAT_L2H_NE_IDX   = 0;
    localparam int STAT_H2L_FULL_IDX = 1;
    localparam int CTRL_IRQEN_IDX    = 0;
    localparam int CTRL_FLUSH_IDX    = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } bus_state_t;

    // STATUS only has a 3-bit count field; deeper FIFOs report 7.
    function automatic logic [2:0] sat_count3(input logic [4:0] c);
        return (c > 5'd7) ? 3'd7 : c[2:0];
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter register.
module sync_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [7:0]                 head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    // Overflowing pushes and underflowing pops are silently dropped.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer update; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/bbc_bus_target.sv
// BBC motherboard bus responder: oversamples phi2 on hsclk, serves a 4-byte
// mailbox window and snoops the paged-ROM select register.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for a synchronized phi2 rise
//   ACTIVE | phi2 high; address latched, read data driven and refreshed
//   HOLD   | phi2 low; read data frozen and held for HOLD_CYCLES
//
// irqb is a plain 0/1 register here; the pad wrapper turns a 1 into z.
module bbc_bus_target
    import bbc_bus_target_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFC40,
    parameter logic [15:0] ROMSEL_ADDR = 16'hFE30,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int          HOLD_CYCLES = 3
) (
    input  logic        hsclk,
    input  logic        rst,
    input  logic        bbc_ck2_phi2,
    input  logic [15:0] bbc_addr,
    input  logic        bbc_rnw,
    input  logic [7:0]  bbc_data_in,
    output logic [7:0]  bbc_data_out,
    output logic        bbc_data_oe,
    output logic        irqb,
    output logic [3:0]  romsel_q,
    output logic        h2l_valid,
    output logic [7:0]  h2l_data,
    input  logic        h2l_ready,
    input  logic        l2h_valid,
    input  logic [7:0]  l2h_data,
    output logic        l2h_ready
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int HCW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_INIT = HCW'(HOLD_CYCLES);

    logic        phi2_sync [SYNC_STAGES];
    logic [15:0] addr_sync [SYNC_STAGES];
    logic        rnw_sync  [SYNC_STAGES];
    logic [7:0]  data_sync [SYNC_STAGES];
    logic        phi2_d;

    logic        phi2_s;
    logic [15:0] addr_s;
    logic        rnw_s;
    logic [7:0]  data_s;
    logic        rise_p;
    logic        fall_p;
    logic        hit_s;
    logic        romsel_s;

    bus_state_t     state;
    logic [1:0]     lat_off;
    logic           lat_rnw;
    logic           lat_hit;
    logic           lat_romsel;
    logic [HCW-1:0] hold_cnt;
    logic           irq_en;

    logic           bus_fall;
    logic           host_wr;
    logic           h2l_push;
    logic           l2h_pop;
    logic           fifo_flush;

    logic [7:0]     l2h_head;
    logic [CW-1:0]  l2h_count;
    logic           l2h_full;
    logic           l2h_empty;
    logic [CW-1:0]  h2l_count_unused;
    logic           h2l_full;
    logic           h2l_empty;

    logic [7:0]     data_val;
    logic [7:0]     status_val;
    logic [7:0]     ctrl_val;

    // Synchronizer chains; all bus inputs share the same depth so they stay
    // aligned with phi2. Left unreset so a reset inside a phi2-high phase
    // does not fabricate a rise edge when it is released.
    always_ff @(posedge hsclk) begin
        phi2_sync[0] <= bbc_ck2_phi2;
        addr_sync[0] <= bbc_addr;
        rnw_sync[0]  <= bbc_rnw;
        data_sync[0] <= bbc_data_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            phi2_sync[i] <= phi2_sync[i-1];
            addr_sync[i] <= addr_sync[i-1];
            rnw_sync[i]  <= rnw_sync[i-1];
            data_sync[i] <= data_sync[i-1];
        end
        phi2_d <= phi2_sync[SYNC_STAGES-1];
    end

    assign phi2_s   = phi2_sync[SYNC_STAGES-1];
    assign addr_s   = addr_sync[SYNC_STAGES-1];
    assign rnw_s    = rnw_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign rise_p   = phi2_s && !phi2_d;
    assign fall_p   = !phi2_s && phi2_d;
    assign hit_s    = (addr_s[15:2] == BASE_ADDR[15:2]);
    assign romsel_s = (addr_s == ROMSEL_ADDR);

    assign bus_fall   = (state == ACTIVE) && fall_p;
    assign host_wr    = bus_fall && !lat_rnw && lat_hit;
    assign h2l_push   = host_wr && (lat_off == REG_DATA);
    assign fifo_flush = host_wr && (lat_off == REG_CTRL) && data_s[CTRL_FLUSH_IDX];
    assign l2h_pop    = bus_fall && lat_rnw && lat_hit && (lat_off == REG_DATA);

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_h2l (
        .clk       (hsclk),
        .rst       (rst),
        .push      (h2l_push),
        .push_data (data_s),
        .pop       (h2l_ready),
        .flush     (fifo_flush),
        .head      (h2l_data),
        .count     (h2l_count_unused),
        .full      (h2l_full),
        .empty     (h2l_empty)
    );

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_l2h (
        .clk       (hsclk),
        .rst       (rst),
        .push      (l2h_valid),
        .push_data (l2h_data),
        .pop       (l2h_pop),
        .flush     (fifo_flush),
        .head      (l2h_head),
        .count     (l2h_count),
        .full      (l2h_full),
        .empty     (l2h_empty)
    );

    assign h2l_valid = !h2l_empty;
    assign l2h_ready = !l2h_full;

    // Register read values, recomputed every cycle so STATUS stays live.
    always_comb begin
        data_val   = l2h_empty ? 8'h00 : l2h_head;
        status_val = '0;
        status_val[STAT_L2H_NE_IDX]   = !l2h_empty;
        status_val[STAT_H2L_FULL_IDX] = h2l_full;
        status_val[6:4]               = sat_count3(5'(l2h_count));
        ctrl_val   = '0;
        ctrl_val[CTRL_IRQEN_IDX]      = irq_en;
    end

    function automatic logic [7:0] sel_reg(input logic [1:0] off,
                                           input logic [7:0] d,
                                           input logic [7:0] s,
                                           input logic [7:0] c);
        case (off)
            REG_DATA:   return d;
            REG_STATUS: return s;
            REG_CTRL:   return c;
            default:    return 8'h00;
        endcase
    endfunction

    // Bus cycle FSM: latch on rise, drive/refresh during phi2 high, hold after fall.
    always_ff @(posedge hsclk) begin
        if (rst) begin
            state        <= IDLE;
            bbc_data_oe  <= 1'b0;
            bbc_data_out <= 8'h00;
            lat_off      <= 2'd0;
            lat_rnw      <= 1'b0;
            lat_hit      <= 1'b0;
            lat_romsel   <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_p) begin
                        lat_off      <= addr_s[1:0];
                        lat_rnw      <= rnw_s;
                        lat_hit      <= hit_s;
                        lat_romsel   <= romsel_s;
                        bbc_data_oe  <= rnw_s && hit_s;
                        bbc_data_out <= sel_reg(addr_s[1:0], data_val, status_val, ctrl_val);
                        state        <= ACTIVE;
                    end else begin
                        bbc_data_oe  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    bbc_data_oe <= lat_rnw && lat_hit;
                    if (lat_rnw && lat_hit) begin
                        bbc_data_out <= sel_reg(lat_off, data_val, status_val, ctrl_val);
                    end
                    if (fall_p) begin
                        if (bbc_data_oe) begin
                            hold_cnt <= HOLD_INIT;
                            state    <= HOLD;
                        end else begin
                            bbc_data_oe <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (rise_p) begin
                        // A new bus cycle pre-empts the hold; oe drops for one
                        // cycle and ACTIVE re-asserts it if this is a read hit.
                        lat_off      <= addr_s[1:0];
                        lat_rnw      <= rnw_s;
                        lat_hit      <= hit_s;
                        lat_romsel   <= romsel_s;
                        bbc_data_oe  <= 1'b0;
                        bbc_data_out <= sel_reg(addr_s[1:0], data_val, status_val, ctrl_val);
                        state        <= ACTIVE;
                    end else if (hold_cnt == '0) begin
                        bbc_data_oe <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    bbc_data_oe <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Control register and ROMSEL snoop, committed at the phi2 fall of a write.
    always_ff @(posedge hsclk) begin
        if (rst) begin
            irq_en   <= 1'b0;
            romsel_q <= 4'h0;
        end else begin
            if (host_wr && (lat_off == REG_CTRL)) irq_en <= data_s[CTRL_IRQEN_IDX];
            if (bus_fall && !lat_rnw && lat_romsel) romsel_q <= data_s[3:0];
        end
    end

    // Interrupt output, one cycle behind the FIFO/enable state.
    always_ff @(posedge hsclk) begin
        if (rst) irqb <= 1'b1;
        else     irqb <= !(irq_en && !l2h_empty);
    end

endmodule

// File: tb/tb_bbc_bus_target.sv
// Directed plus randomized bench for bbc_bus_target with a queue-based
// mailbox model of the register window.
module tb_bbc_bus_target;

    logic        hsclk;
    logic        rst;
    logic        bbc_ck2_phi2;
    logic [15:0] bbc_addr;
    logic        bbc_rnw;
    logic [7:0]  bbc_data_in;
    logic [7:0]  bbc_data_out;
    logic        bbc_data_oe;
    logic        irqb;
    logic [3:0]  romsel_q;
    logic        h2l_valid;
    logic [7:0]  h2l_data;
    logic        h2l_ready;
    logic        l2h_valid;
    logic [7:0]  l2h_data;
    logic        l2h_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_h2l [$];
    logic [7:0] m_l2h [$];
    logic       m_irq_en;
    logic [3:0] m_romsel;

    bbc_bus_target dut (
        .hsclk        (hsclk),
        .rst          (rst),
        .bbc_ck2_phi2 (bbc_ck2_phi2),
        .bbc_addr     (bbc_addr),
        .bbc_rnw      (bbc_rnw),
        .bbc_data_in  (bbc_data_in),
        .bbc_data_out (bbc_data_out),
        .bbc_data_oe  (bbc_data_oe),
        .irqb         (irqb),
        .romsel_q     (romsel_q),
        .h2l_valid    (h2l_valid),
        .h2l_data     (h2l_data),
        .h2l_ready    (h2l_ready),
        .l2h_valid    (l2h_valid),
        .l2h_data     (l2h_data),
        .l2h_ready    (l2h_ready)
    );

    initial hsclk = 1'b0;
    always #5 hsclk = ~hsclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_h2l.delete();
        m_l2h.delete();
        m_irq_en = 1'b0;
        m_romsel = 4'h0;
    endtask

    function automatic logic [7:0] model_status();
        int n;
        n = m_l2h.size();
        return {1'b0, 3'((n > 7) ? 7 : n), 2'b00, 1'(m_h2l.size() == 4), 1'(n > 0)};
    endfunction

    function automatic logic [7:0] model_read(input logic [1:0] off);
        case (off)
            2'd0:    return (m_l2h.size() > 0) ? m_l2h[0] : 8'h00;
            2'd1:    return model_status();
            2'd2:    return {7'b0, m_irq_en};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic in_window(input logic [15:0] a);
        return a[15:2] == 14'(16'hFC40 >> 2);
    endfunction

    task automatic bus_cycle(input logic [15:0] a, input logic rnw, input logic [7:0] wd,
                             output logic [7:0] rd, output logic oe_seen);
        @(negedge hsclk);
        bbc_addr    = a;
        bbc_rnw     = rnw;
        bbc_data_in = wd;
        repeat (2) @(negedge hsclk);
        bbc_ck2_phi2 = 1'b1;
        oe_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge hsclk);
            if (bbc_data_oe) oe_seen = 1'b1;
        end
        rd = bbc_data_out;
        bbc_ck2_phi2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge hsclk);
            if (bbc_data_oe && !rnw) oe_seen = 1'b1;
        end
    endtask

    task automatic host_write(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] rd;
        logic       oe_seen;
        bus_cycle(a, 1'b0, d, rd, oe_seen);
        chk("wr_no_oe", oe_seen, 1'b0);
        if (in_window(a)) begin
            if (a[1:0] == 2'd0) begin
                if (m_h2l.size() < 4) m_h2l.push_back(d);
            end else if (a[1:0] == 2'd2) begin
                m_irq_en = d[0];
                if (d[1]) begin
                    m_h2l.delete();
                    m_l2h.delete();
                end
            end
        end else if (a == 16'hFE30) begin
            m_romsel = d[3:0];
        end
    endtask

    task automatic host_read(input string tag, input logic [15:0] a);
        logic [7:0] rd;
        logic [7:0] exp;
        logic       oe_seen;
        logic       hit;
        hit = in_window(a);
        exp = model_read(a[1:0]);
        bus_cycle(a, 1'b1, 8'($urandom), rd, oe_seen);
        chk({tag, "_oe"}, oe_seen, hit);
        if (hit) chk(tag, rd, exp);
        if (hit && a[1:0] == 2'd0 && m_l2h.size() > 0) void'(m_l2h.pop_front());
    endtask

    task automatic local_push(input logic [7:0] d);
        @(negedge hsclk);
        chk("l2h_ready", l2h_ready, m_l2h.size() < 4);
        l2h_valid = 1'b1;
        l2h_data  = d;
        @(negedge hsclk);
        l2h_valid = 1'b0;
        if (m_l2h.size() < 4) m_l2h.push_back(d);
        repeat (2) @(negedge hsclk);
    endtask

    task automatic local_pop();
        @(negedge hsclk);
        chk("h2l_valid", h2l_valid, m_h2l.size() > 0);
        if (m_h2l.size() > 0) chk("h2l_data", h2l_data, m_h2l[0]);
        h2l_ready = 1'b1;
        @(negedge hsclk);
        h2l_ready = 1'b0;
        if (m_h2l.size() > 0) void'(m_h2l.pop_front());
        @(negedge hsclk);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_irqb"},   irqb, !(m_irq_en && m_l2h.size() > 0));
        chk({tag, "_romsel"}, romsel_q, m_romsel);
        chk({tag, "_h2lv"},   h2l_valid, m_h2l.size() > 0);
        chk({tag, "_l2hr"},   l2h_ready, m_l2h.size() < 4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (4) @(negedge hsclk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic saw_drop;
        logic saw_reassert;
        logic [7:0] d;

        rst          = 1'b1;
        bbc_ck2_phi2 = 1'b0;
        bbc_addr     = 16'h0000;
        bbc_rnw      = 1'b1;
        bbc_data_in  = 8'h00;
        h2l_ready    = 1'b0;
        l2h_valid    = 1'b0;
        l2h_data     = 8'h00;
        model_reset();
        repeat (5) @(negedge hsclk);
        rst = 1'b0;
        @(negedge hsclk);

        // reset state
        chk("rst_oe",      bbc_data_oe, 1'b0);
        chk("rst_dout",    bbc_data_out, 8'h00);
        chk("rst_irqb",    irqb, 1'b1);
        chk("rst_romsel",  romsel_q, 4'h0);
        chk("rst_h2lv",    h2l_valid, 1'b0);
        chk("rst_l2hr",    l2h_ready, 1'b1);

        // host write then local pop
        host_write(16'hFC40, 8'hA5);
        chk("h2l_after_wr", h2l_valid, 1'b1);
        chk("h2l_data_a5",  h2l_data, 8'hA5);
        local_pop();
        chk("h2l_cleared",  h2l_valid, 1'b0);

        // local pushes, host reads status and data, then an empty read
        local_push(8'h11);
        local_push(8'h22);
        local_push(8'h33);
        host_read("status31", 16'hFC41);
        chk("status31_const", model_status(), 8'h31);
        host_read("rd11", 16'hFC40);
        host_read("rd22", 16'hFC40);
        host_read("rd33", 16'hFC40);
        host_read("rd_empty", 16'hFC40);
        host_read("status00", 16'hFC41);

        // irq enable and interrupt
        host_write(16'hFC42, 8'h01);
        repeat (2) @(negedge hsclk);
        chk("irq_idle", irqb, 1'b1);
        local_push(8'h5A);
        chk("irq_set", irqb, 1'b0);
        host_read("rd_irq", 16'hFC40);
        chk("irq_clr", irqb, 1'b1);
        host_read("ctrl_rd", 16'hFC42);

        // h2l overflow: 5 writes into a 4-entry FIFO
        for (int i = 0; i < 5; i++) host_write(16'hFC40, 8'(8'h60 + i));
        host_read("status_full", 16'hFC41);
        for (int i = 0; i < 5; i++) local_pop();
        check_outputs("ovf");

        // ROMSEL snoop
        host_write(16'hFE30, 8'h0C);
        chk("romsel_c", romsel_q, 4'hC);
        host_read("romsel_rd", 16'hFE30);
        chk("romsel_keep", romsel_q, 4'hC);

        // pre-empting phi2 rise during the hold window
        @(negedge hsclk);
        bbc_addr = 16'hFC41;
        bbc_rnw  = 1'b1;
        repeat (2) @(negedge hsclk);
        bbc_ck2_phi2 = 1'b1;
        repeat (8) @(negedge hsclk);
        chk("pre_oe_first", bbc_data_oe, 1'b1);
        bbc_ck2_phi2 = 1'b0;
        repeat (2) @(negedge hsclk);
        bbc_ck2_phi2 = 1'b1;
        saw_drop     = 1'b0;
        saw_reassert = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge hsclk);
            if (!bbc_data_oe) saw_drop = 1'b1;
            else if (saw_drop) saw_reassert = 1'b1;
        end
        chk("pre_drop",     saw_drop, 1'b1);
        chk("pre_reassert", saw_reassert, 1'b1);
        chk("pre_data",     bbc_data_out, model_status());
        bbc_ck2_phi2 = 1'b0;
        repeat (10) @(negedge hsclk);

        // reset pulsed mid-ACTIVE during a read
        bbc_addr = 16'hFC41;
        bbc_rnw  = 1'b1;
        repeat (2) @(negedge hsclk);
        bbc_ck2_phi2 = 1'b1;
        repeat (5) @(negedge hsclk);
        chk("midrst_oe_before", bbc_data_oe, 1'b1);
        rst = 1'b1;
        @(negedge hsclk);
        chk("midrst_oe_after", bbc_data_oe, 1'b0);
        repeat (2) @(negedge hsclk);
        rst = 1'b0;
        model_reset();
        bbc_ck2_phi2 = 1'b0;
        repeat (8) @(negedge hsclk);

        // reset pulsed mid-ACTIVE during a write: the write is lost
        bbc_addr    = 16'hFC40;
        bbc_rnw     = 1'b0;
        bbc_data_in = 8'h77;
        repeat (2) @(negedge hsclk);
        bbc_ck2_phi2 = 1'b1;
        repeat (5) @(negedge hsclk);
        rst = 1'b1;
        repeat (2) @(negedge hsclk);
        rst = 1'b0;
        repeat (2) @(negedge hsclk);
        bbc_ck2_phi2 = 1'b0;
        repeat (8) @(negedge hsclk);
        check_outputs("midrst_wr");

        // randomized traffic against the mailbox model
        for (int n = 0; n < 80; n++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 8))
                0, 1:    host_write(16'hFC40, d);
                2:       host_read("rnd_data", 16'hFC40);
                3:       host_read("rnd_status", 16'hFC41);
                4:       host_write(16'hFC42, {d[7:2], ($urandom_range(0, 7) == 0), d[0]});
                5:       host_read("rnd_ctrl", 16'hFC42);
                6:       local_push(d);
                7:       local_pop();
                default: begin
                    host_write(16'hFE30, d);
                    host_read("rnd_reg3", 16'hFC43);
                end
            endcase
            check_outputs("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
